// File: rtl/coef_mem_pkg.sv
// rtl/coef_mem_pkg.sv - shared state type and default-coefficient functions
package coef_mem_pkg;

  // Wide enough for any packed word the loader is likely to be built with.
  localparam int MAX_WORD_W = 256;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Default matrix element: row index + 1, where j = row + rows*col.
  function automatic int default_elem(input int j, input int rows, input int elem_w);
    return ((j % rows) + 1) & ((1 << elem_w) - 1);
  endfunction

  // Packs elements pack*w .. pack*w+pack-1, lowest index in the LSBs.
  // Elements past the end of the matrix stay zero.
  function automatic logic [MAX_WORD_W-1:0] default_word(input int w, input int rows,
                                                         input int cols, input int pack,
                                                         input int elem_w);
    logic [MAX_WORD_W-1:0] word;
    int j;
    word = '0;
    for (int p = 0; p < pack; p++) begin
      j = pack * w + p;
      if (j < rows * cols) begin
        word = word | (MAX_WORD_W'(default_elem(j, rows, elem_w)) << (p * elem_w));
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/coef_mem_init_gen.sv
// rtl/coef_mem_init_gen.sv - load counter and default-word generator
module coef_mem_init_gen
  import coef_mem_pkg::*;
#(
  parameter int ELEM_W = 7,
  parameter int PACK   = 2,
  parameter int ROWS   = 8,
  parameter int COLS   = 4,
  parameter int DEPTH  = 16,
  localparam int WORD_W = ELEM_W * PACK,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [WORD_W-1:0] init_data,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign init_we   = enable;
  assign init_addr = cnt_q;
  assign last      = (cnt_q == LAST_ADDR);
  assign init_data = WORD_W'(default_word(int'(cnt_q), ROWS, COLS, PACK, ELEM_W));

  // Next load address: restart wins; wrap after the final word so an idle counter sits at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Load counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coef_mem_loader.sv
// rtl/coef_mem_loader.sv - coefficient store with self-initialising load and runtime overwrite
module coef_mem_loader
  import coef_mem_pkg::*;
#(
  parameter int ELEM_W = 7,
  parameter int PACK   = 2,
  parameter int ROWS   = 8,
  parameter int COLS   = 4,
  parameter int DEPTH  = 16,
  localparam int WORD_W = ELEM_W * PACK,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_err,
  output logic              load_done,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              init_we, init_last;
  logic [ADDR_W-1:0] init_addr;
  logic [WORD_W-1:0] init_data;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic              wr_in_range, rd_in_range;

  coef_mem_init_gen #(
    .ELEM_W(ELEM_W),
    .PACK  (PACK),
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DEPTH (DEPTH)
  ) u_init_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (state_q == INIT),
    .restart  (reload_start),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .last     (init_last)
  );

  assign busy        = (state_q == INIT);
  assign load_done   = (state_q == READY);
  assign wr_ready    = (state_q == READY);
  assign rd_valid    = rd_valid_q;
  assign rd_err      = rd_err_q;
  assign rd_data     = rd_data_q;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

  // Next state: reload always restarts INIT; INIT finishes on the last default word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: begin
        if (!reload_start && init_last) state_d = READY;
      end
      READY: begin
        if (reload_start) state_d = INIT;
      end
    endcase
  end

  // Write port mux: loader owns the array in INIT, external writes in READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_addr;
    mem_wdata = init_data;
    if (state_q == INIT) begin
      mem_we = init_we;
    end else if (wr_valid && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Read port: old contents are sampled, so a same-address write is read-first.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      if (state_q == READY && rd_in_range) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem_q[rd_addr];
      end else begin
        rd_err_d = 1'b1;
      end
    end
  end

  // FSM state and read-port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Coefficient array; contents survive reset and are rebuilt by the loader.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_coef_mem_loader.sv
// tb/tb_coef_mem_loader.sv - self-checking bench for coef_mem_loader (DEPTH 16 and 20)
module tb_coef_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0]       reload, wr_valid, rd_en;
  logic [1:0][4:0]  wr_addr, rd_addr;
  logic [1:0][13:0] wr_data;
  logic [1:0]       wr_ready, rd_valid, rd_err, load_done, busy;
  logic [1:0][13:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state, one slot per instance.
  bit          m_loading [2];
  int          m_count   [2];
  bit          m_valid   [2];
  bit          m_err     [2];
  logic [13:0] m_data    [2];
  logic [13:0] m_mem     [2][32];

  logic [13:0] pat [4];

  always #5 clk = ~clk;

  coef_mem_loader u_a (
    .clk(clk), .rst(rst), .reload_start(reload[0]),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0][3:0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0][3:0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .rd_err(rd_err[0]), .load_done(load_done[0]), .busy(busy[0])
  );

  coef_mem_loader #(.DEPTH(20)) u_b (
    .clk(clk), .rst(rst), .reload_start(reload[1]),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .rd_err(rd_err[1]), .load_done(load_done[1]), .busy(busy[1])
  );

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 20;
  endfunction

  // Word w of the default matrix: elements 2w and 2w+1, value = (index mod 8) + 1.
  function automatic logic [13:0] exp_default(input int w);
    int lo, hi;
    if (2 * w >= 32) return 14'h0;
    lo = ((2 * w) % 8) + 1;
    hi = ((2 * w + 1) % 8) + 1;
    return 14'(hi * 128 + lo);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    reload   = '0;
    wr_valid = '0;
    rd_en    = '0;
    wr_addr  = '0;
    rd_addr  = '0;
    wr_data  = '0;
  endtask

  task automatic model_edge(input int i);
    bit was_loading;
    was_loading = m_loading[i];
    if (rd_en[i]) begin
      if (was_loading || int'(rd_addr[i]) >= dep(i)) begin
        m_valid[i] = 1'b0;
        m_err[i]   = 1'b1;
      end else begin
        m_valid[i] = 1'b1;
        m_err[i]   = 1'b0;
        m_data[i]  = m_mem[i][rd_addr[i]];
      end
    end else begin
      m_valid[i] = 1'b0;
      m_err[i]   = 1'b0;
    end
    if (!was_loading && wr_valid[i] && int'(wr_addr[i]) < dep(i)) m_mem[i][wr_addr[i]] = wr_data[i];
    if (reload[i]) begin
      m_loading[i] = 1'b1;
      m_count[i]   = dep(i);
    end else if (was_loading) begin
      m_count[i]--;
      if (m_count[i] == 0) begin
        m_loading[i] = 1'b0;
        for (int w = 0; w < dep(i); w++) m_mem[i][w] = exp_default(w);
      end
    end
  endtask

  // Model: a load is DEPTH edges of unavailability, after which the whole array holds defaults.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          m_loading[i] = 1'b1;
          m_count[i]   = dep(i);
          m_valid[i]   = 1'b0;
          m_err[i]     = 1'b0;
          m_data[i]    = 14'h0;
        end else begin
          model_edge(i);
        end
      end
    end
  end

  // Compare every output of both instances against the model once per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("load_done[%0d]", i), int'(load_done[i]), int'(!m_loading[i]));
          chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_loading[i]));
          chk($sformatf("wr_ready[%0d]", i), int'(wr_ready[i]), int'(!m_loading[i]));
          chk($sformatf("rd_valid[%0d]", i), int'(rd_valid[i]), int'(m_valid[i]));
          chk($sformatf("rd_err[%0d]", i), int'(rd_err[i]), int'(m_err[i]));
          chk($sformatf("rd_data[%0d]", i), int'(rd_data[i]), int'(m_data[i]));
        end
      end
    end
  end

  initial begin
    pat[0] = 14'h0101;
    pat[1] = 14'h0203;
    pat[2] = 14'h0305;
    pat[3] = 14'h0407;
    idle();
    rst = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", int'(busy[i]), 1);
      chk("rst_load_done", int'(load_done[i]), 0);
      chk("rst_wr_ready", int'(wr_ready[i]), 0);
      chk("rst_rd_valid", int'(rd_valid[i]), 0);
    end

    // Release and time the initial load; read attempt on edge 3.
    rst = 1'b1;
    tick();
    tick();
    rd_en[0] = 1'b1; rd_addr[0] = 5'd0;
    tick();
    chk("init_rd_err", int'(rd_err[0]), 1);
    chk("init_rd_valid", int'(rd_valid[0]), 0);
    chk("init_rd_data", int'(rd_data[0]), 0);
    rd_en[0] = 1'b0;
    tick();
    chk("init_rd_err_pulse", int'(rd_err[0]), 0);
    repeat (11) tick();
    chk("a_done_edge15", int'(load_done[0]), 0);
    chk("a_busy_edge15", int'(busy[0]), 1);
    tick();
    chk("a_done_edge16", int'(load_done[0]), 1);
    chk("a_wr_ready_edge16", int'(wr_ready[0]), 1);
    repeat (3) tick();
    chk("b_done_edge19", int'(load_done[1]), 0);
    tick();
    chk("b_done_edge20", int'(load_done[1]), 1);

    // Default contents.
    for (int w = 0; w < 16; w++) begin
      rd_en[0] = 1'b1; rd_addr[0] = 5'(w);
      tick();
      chk($sformatf("a_default_w%0d", w), int'(rd_data[0]), int'(pat[w % 4]));
    end
    rd_en[0] = 1'b0;
    for (int w = 16; w < 20; w++) begin
      rd_en[1] = 1'b1; rd_addr[1] = 5'(w);
      tick();
      chk($sformatf("b_default_w%0d", w), int'(rd_data[1]), 0);
    end
    rd_addr[1] = 5'd1;
    tick();
    chk("b_default_w1", int'(rd_data[1]), 'h0203);

    // Out-of-range write and read on the DEPTH=20 instance.
    rd_en[1] = 1'b0;
    wr_valid[1] = 1'b1; wr_addr[1] = 5'd25; wr_data[1] = 14'h2AAA;
    tick();
    wr_valid[1] = 1'b0;
    rd_en[1] = 1'b1; rd_addr[1] = 5'd25;
    tick();
    chk("b_oor_rd_err", int'(rd_err[1]), 1);
    chk("b_oor_rd_valid", int'(rd_valid[1]), 0);
    chk("b_oor_rd_data_held", int'(rd_data[1]), 'h0203);
    rd_addr[1] = 5'd5;
    tick();
    chk("b_w5_after_oor", int'(rd_data[1]), 'h0203);
    rd_addr[1] = 5'd9;
    tick();
    chk("b_w9_after_oor", int'(rd_data[1]), 'h0203);
    rd_en[1] = 1'b0;

    // External write with same-cycle read (read-first), then read-back.
    wr_valid[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 14'h1ABC;
    rd_en[0] = 1'b1; rd_addr[0] = 5'd5;
    tick();
    chk("a_read_first", int'(rd_data[0]), 'h0203);
    wr_valid[0] = 1'b0;
    tick();
    chk("a_read_back", int'(rd_data[0]), 'h1ABC);
    rd_en[0] = 1'b0;

    // Reload with a write in the same cycle; a write attempt during INIT is ignored.
    reload[0] = 1'b1;
    wr_valid[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 14'h1111;
    tick();
    reload[0] = 1'b0;
    chk("reload_done_low", int'(load_done[0]), 0);
    chk("reload_wr_ready_low", int'(wr_ready[0]), 0);
    chk("reload_busy", int'(busy[0]), 1);
    for (int k = 1; k <= 16; k++) begin
      wr_valid[0] = (k == 12);
      wr_addr[0] = 5'd3; wr_data[0] = 14'h3FFF;
      tick();
      if (k == 15) chk("reload_done_k15", int'(load_done[0]), 0);
      if (k == 16) chk("reload_done_k16", int'(load_done[0]), 1);
    end
    wr_valid[0] = 1'b0;
    rd_en[0] = 1'b1; rd_addr[0] = 5'd5;
    tick();
    chk("reload_w5_restored", int'(rd_data[0]), 'h0203);
    rd_addr[0] = 5'd3;
    tick();
    chk("reload_w3_untouched", int'(rd_data[0]), 'h0407);
    rd_en[0] = 1'b0;

    // Reload again at cnt = 10 of a load in progress.
    reload[0] = 1'b1;
    tick();
    reload[0] = 1'b0;
    repeat (10) tick();
    reload[0] = 1'b1;
    tick();
    reload[0] = 1'b0;
    repeat (15) tick();
    chk("midinit_reload_k15", int'(load_done[0]), 0);
    tick();
    chk("midinit_reload_k16", int'(load_done[0]), 1);

    // Reset at cnt = 7 of a load in progress.
    reload[0] = 1'b1;
    tick();
    reload[0] = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    chk("abort_a_busy", int'(busy[0]), 1);
    chk("abort_a_done", int'(load_done[0]), 0);
    chk("abort_b_busy", int'(busy[1]), 1);
    chk("abort_b_done", int'(load_done[1]), 0);
    tick();
    rst = 1'b1;
    repeat (15) tick();
    chk("abort_a_k15", int'(load_done[0]), 0);
    tick();
    chk("abort_a_k16", int'(load_done[0]), 1);
    repeat (3) tick();
    chk("abort_b_k19", int'(load_done[1]), 0);
    tick();
    chk("abort_b_k20", int'(load_done[1]), 1);
    rd_en[0] = 1'b1; rd_addr[0] = 5'd5;
    rd_en[1] = 1'b1; rd_addr[1] = 5'd18;
    tick();
    chk("abort_a_w5", int'(rd_data[0]), 'h0203);
    chk("abort_b_w18", int'(rd_data[1]), 0);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coef_mem_loader.md
Name: coef_mem_loader

Overview:
- Parametrised coefficient store for the matrix datapath.
- After reset, a load FSM self-initialises the memory with default matrix constants, one packed word per cycle, then raises `load_done`.
- Serves registered reads to the MAC array.
- Adds a runtime overwrite port (valid/ready) and a restart-load command, so coefficients can change without a full reset.

Parameters:
- ELEM_W, 7, bits per matrix element.
- PACK, 2, elements packed per memory word (element 2w in LSBs).
- ROWS, 8, matrix rows; default element value = row index + 1.
- COLS, 4, matrix columns.
- DEPTH, 16, memory words; must be ≥ ceil(ROWS*COLS/PACK).
- Derived localparams: WORD_W = ELEM_W*PACK (14), ADDR_W = clog2(DEPTH) (4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- reload_start  in  1  pulse: restart default load from word 0.
- wr_valid  in  1  external write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  WORD_W  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read word address.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  WORD_W  read data.
- rd_err  out  1  one-cycle pulse: read rejected (load in progress or addr ≥ DEPTH).
- load_done  out  1  default load complete, memory usable.
- busy  out  1  load FSM in INIT.

Behaviour:
- Reset (rst=0, async): state INIT, load counter = 0. All outputs 0 except busy = 1. Memory contents are not reset.
- Element index j = row + ROWS*col. Default element value = (j mod ROWS) + 1, truncated to ELEM_W. Indices ≥ ROWS*COLS default to 0.
- Word w holds elements PACK*w … PACK*w+PACK-1, lowest index in the LSBs.
- INIT: each edge writes default word[cnt], cnt++.
  - The edge writing word DEPTH-1 moves the FSM to READY; load_done = 1 and busy = 0 from that edge.
  - load_done is therefore high after exactly DEPTH edges following reset release.
- READY: wr_ready = 1. An accepted write updates mem[wr_addr] at the edge. wr_addr ≥ DEPTH is accepted but discarded.
- Read latency: 1 cycle. rd_en at edge N in READY with rd_addr < DEPTH gives rd_valid = 1 and rd_data = mem[rd_addr] after edge N. Otherwise rd_valid = 0 and rd_data holds its last value.
- Read and write to the same address in the same cycle: read-first, returns the old data.
- rd_en in INIT, or with rd_addr ≥ DEPTH: rd_valid = 0, rd_err = 1 for one cycle.
- reload_start in READY: next edge enters INIT with cnt = 0; load_done, wr_ready → 0; busy → 1. A write presented that same cycle is still accepted (wr_ready was 1), then overwritten by the reload.
- reload_start in INIT: cnt restarts at 0; the sequence runs DEPTH more cycles.
- reload_start and reset together: reset wins.
- Reset asserted mid-INIT or mid-READY: immediate return to reset state; the full load repeats after release.
- wr_ready is 0 in INIT; wr_valid there is ignored (no side effects).

Decomposition:
- Package coef_mem_pkg:
  - state enum {INIT, READY}
  - function default_elem(j, ROWS, ELEM_W)
  - function default_word(w, …) packing PACK elements
- One sub-module, coef_mem_init_gen: the load counter plus default-word generator. Outputs init_we, init_addr, init_data and last.
- Top module: FSM, write-port arbitration, memory array, read register.

Test Plan:
- Reset release, defaults: load_done rises exactly 16 edges after release; busy high throughout. Reading words 0..15 returns 0x0101, 0x0203, 0x0305, 0x0407, then the same 4-word pattern repeats (word 4 = 0x0101).
- Read during INIT: rd_en at cycle 3 → rd_valid = 0, rd_err one-cycle pulse, rd_data unchanged.
- External write: write 0x1ABC to addr 5 in READY, read addr 5 the next cycle → 0x1ABC. Same-cycle read of addr 5 during the write → 0x0203 (old value).
- Reload: after writing addr 5, pulse reload_start → load_done low for 16 cycles, wr_ready low. Afterwards addr 5 reads 0x0203 again.
- Reload mid-INIT plus reset abort: reload_start at cnt = 10 → load_done at 16 edges after the pulse. rst low at cnt = 7 → busy = 1, load_done = 0 immediately; full 16-cycle load after release.
- Out-of-range: DEPTH=20 instance (ADDR_W=5). Write to addr 25 is ignored. Read of addr 25 → rd_err = 1, rd_valid = 0. Words 16..19 read 0.
